tla_cap_ctrl: RTL and testbench

//  Capture controller in the Gc_clk125 domain, directly downstream of the Gc_adc_* outputs of the TLA

---
 rtl/tla_pkg.sv | 21 ++
 rtl/tla_sat_cnt.sv | 34 +++
 rtl/tla_cap_ctrl.sv | 151 +++++++++++++++
 tb/tb_tla_cap_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tla_pkg.sv
// Shared definitions for the TLA capture controller: FSM state encoding and
// the width of the {overflow, sample} word written to the capture RAM.
package tla_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CAPT = 3'd2,
    ST_CMPT = 3'd3,
    ST_REL  = 3'd4
  } cap_state_e;

  localparam int unsigned ADC_W_DEF      = 14;
  localparam int unsigned CAP_WORD_W_DEF = ADC_W_DEF + 1;

  // The RAM word carries the overflow flag above the sample bits.
  function automatic int unsigned cap_word_w(input int unsigned adc_w);
    return adc_w + 1;
  endfunction

endpackage

// File: rtl/tla_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module tla_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tla_cap_ctrl.sv
// Capture controller: four-phase trigger handshake with the analog side, then
// len samples {of, data} written to the capture RAM with one clock of latency.
module tla_cap_ctrl
  import tla_pkg::*;
#(
  parameter int unsigned ADC0_0 = 14,
  parameter int unsigned ADC0_2 = 2,
  parameter int unsigned CAP0_0 = 16,
  parameter int unsigned CAP0_1 = 1024
) (
  input  logic                  Gc_clk125,
  input  logic                  Gc_rst,
  input  logic                  Gc_cap_start,
  input  logic                  Gc_cap_abort,
  input  logic [CAP0_0-1:0]     Gc_cap_len,
  input  logic [ADC0_2-1:0]     Gc_phase_sel,
  input  logic                  Gc_adc_of,
  input  logic [ADC0_0-1:0]     Gc_adc_data,
  input  logic                  Gc_capr_rdy,
  output logic                  Gc_cap_trig,
  output logic                  Gc_cap_cmpt,
  output logic [ADC0_2-1:0]     Gc_cap_phase,
  output logic                  Gc_wr_en,
  output logic [CAP0_0-1:0]     Gc_wr_addr,
  output logic [ADC0_0:0]       Gc_wr_data,
  output logic                  Gc_cap_busy,
  output logic                  Gc_cap_done,
  output logic                  Gc_cap_err,
  output logic [CAP0_0-1:0]     Gc_of_cnt
);

  localparam int unsigned WORD_W = cap_word_w(ADC0_0);
  localparam int unsigned TMO_W  = (CAP0_1 > 2) ? $clog2(CAP0_1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CAP0_1 - 1);

  cap_state_e          state_q;
  logic                trig_q, cmpt_q, done_q, err_q, wr_en_q;
  logic [CAP0_0-1:0]   wr_addr_q, len_q, idx_q;
  logic [WORD_W-1:0]   wr_data_q;
  logic [ADC0_2-1:0]   phase_q;
  logic [TMO_W-1:0]    tmo_q;

  logic abort_act, start_ok, of_inc;

  // Abort only matters once a capture is in flight, and it outranks a start.
  assign abort_act = Gc_cap_abort && (state_q != ST_IDLE);
  assign start_ok  = Gc_cap_start && !Gc_cap_abort && !Gc_capr_rdy && (state_q == ST_IDLE);
  assign of_inc    = (state_q == ST_CAPT) && !abort_act && Gc_adc_of;

  always_ff @(posedge Gc_clk125) begin
    if (Gc_rst) begin
      state_q   <= ST_IDLE;
      trig_q    <= 1'b0;
      cmpt_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      phase_q   <= '0;
      tmo_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_en_q <= 1'b0;
      if (abort_act) begin
        trig_q  <= 1'b0;
        cmpt_q  <= 1'b0;
        state_q <= ST_REL;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start_ok) begin
              len_q     <= Gc_cap_len;
              phase_q   <= Gc_phase_sel;
              wr_addr_q <= '0;
              idx_q     <= '0;
              tmo_q     <= '0;
              trig_q    <= 1'b1;
              state_q   <= ST_REQ;
            end
          end
          ST_REQ: begin
            // rdy is tested before the timeout so it wins a same-cycle tie.
            if (Gc_capr_rdy) begin
              if (len_q == '0) begin
                trig_q  <= 1'b0;
                cmpt_q  <= 1'b1;
                state_q <= ST_CMPT;
              end else begin
                state_q <= ST_CAPT;
              end
            end else if (tmo_q == TMO_LAST) begin
              trig_q  <= 1'b0;
              err_q   <= 1'b1;
              state_q <= ST_REL;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          ST_CAPT: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q;
            wr_data_q <= {Gc_adc_of, Gc_adc_data};
            idx_q     <= idx_q + 1'b1;
            if (idx_q == (len_q - 1'b1)) begin
              trig_q  <= 1'b0;
              cmpt_q  <= 1'b1;
              state_q <= ST_CMPT;
            end
          end
          ST_CMPT: begin
            if (!Gc_capr_rdy) begin
              cmpt_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          ST_REL: begin
            if (!Gc_capr_rdy) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  tla_sat_cnt #(.W(CAP0_0)) u_of_cnt (
    .clk_i (Gc_clk125),
    .rst_i (Gc_rst),
    .clr_i (start_ok),
    .inc_i (of_inc),
    .cnt_o (Gc_of_cnt)
  );

  assign Gc_cap_trig  = trig_q;
  assign Gc_cap_cmpt  = cmpt_q;
  assign Gc_cap_phase = phase_q;
  assign Gc_wr_en     = wr_en_q && !abort_act;
  assign Gc_wr_addr   = wr_addr_q;
  assign Gc_wr_data   = wr_data_q;
  assign Gc_cap_busy  = (state_q != ST_IDLE);
  assign Gc_cap_done  = done_q;
  assign Gc_cap_err   = err_q;

endmodule

// File: tb/tb_tla_cap_ctrl.sv
// Directed bench for tla_cap_ctrl: handshake, writes, overflow count, timeout,
// abort, len==0, ignored starts, mid-capture reset, and 8-bit saturation.
module tb_tla_cap_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, adc_of, rdy;
  logic [15:0] len;
  logic [1:0]  phase_sel;
  logic [13:0] adc_data;
  logic        trig, cmpt, wr_en, busy, done, err;
  logic [1:0]  cap_phase;
  logic [15:0] wr_addr, of_cnt;
  logic [14:0] wr_data;

  logic        start8, rdy8;
  logic [7:0]  len8;
  logic        trig8, cmpt8, wr_en8, busy8, done8, err8;
  logic [1:0]  cap_phase8;
  logic [7:0]  wr_addr8, of_cnt8;
  logic [14:0] wr_data8;

  always #4 clk = ~clk;

  tla_cap_ctrl dut (
    .Gc_clk125(clk), .Gc_rst(rst), .Gc_cap_start(start), .Gc_cap_abort(abort),
    .Gc_cap_len(len), .Gc_phase_sel(phase_sel), .Gc_adc_of(adc_of),
    .Gc_adc_data(adc_data), .Gc_capr_rdy(rdy), .Gc_cap_trig(trig),
    .Gc_cap_cmpt(cmpt), .Gc_cap_phase(cap_phase), .Gc_wr_en(wr_en),
    .Gc_wr_addr(wr_addr), .Gc_wr_data(wr_data), .Gc_cap_busy(busy),
    .Gc_cap_done(done), .Gc_cap_err(err), .Gc_of_cnt(of_cnt)
  );

  tla_cap_ctrl #(.CAP0_0(8)) dut8 (
    .Gc_clk125(clk), .Gc_rst(rst), .Gc_cap_start(start8), .Gc_cap_abort(1'b0),
    .Gc_cap_len(len8), .Gc_phase_sel(phase_sel), .Gc_adc_of(adc_of),
    .Gc_adc_data(adc_data), .Gc_capr_rdy(rdy8), .Gc_cap_trig(trig8),
    .Gc_cap_cmpt(cmpt8), .Gc_cap_phase(cap_phase8), .Gc_wr_en(wr_en8),
    .Gc_wr_addr(wr_addr8), .Gc_wr_data(wr_data8), .Gc_cap_busy(busy8),
    .Gc_cap_done(done8), .Gc_cap_err(err8), .Gc_of_cnt(of_cnt8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Write monitor: each write must carry the sample presented one clock earlier.
  logic [15:0] addr_log[$];
  logic [14:0] data_log[$];
  logic [14:0] exp_log[$];
  logic [14:0] prev_in = '0;
  int done_n = 0, err_n = 0, wr8_n = 0;
  logic [7:0] last_addr8 = '0;

  always @(negedge clk) begin
    if (wr_en) begin
      addr_log.push_back(wr_addr);
      data_log.push_back(wr_data);
      exp_log.push_back(prev_in);
    end
    if (done) done_n++;
    if (err)  err_n++;
    if (wr_en8) begin
      wr8_n++;
      last_addr8 = wr_addr8;
    end
    prev_in = {adc_of, adc_data};
  end

  task automatic step();
    @(posedge clk);
    #1;
    adc_data = adc_data + 14'd3;
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return cmpt;
      1:       return done;
      2:       return wr_en;
      default: return cmpt8;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input int budget);
    int n = 0;
    while (!cond(which) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_seen"}, 32'(cond(which)), 32'd1);
  endtask

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    exp_log.delete();
  endtask

  task automatic pulse_start(input logic [15:0] l, input logic [1:0] ph);
    len = l; phase_sel = ph; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n, of_writes, d0;
    rst = 1'b1; start = 0; abort = 0; adc_of = 0; rdy = 0; len = 0;
    phase_sel = 0; adc_data = 14'd100; start8 = 0; rdy8 = 0; len8 = 0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_trig", 32'(trig), 0);
    check("rst_cmpt", 32'(cmpt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_of_cnt", 32'(of_cnt), 0);
    check("rst_phase", 32'(cap_phase), 0);
    check("rst_busy8", 32'(busy8), 0);

    // len=8, rdy rises 5 cycles after trig
    clear_logs();
    pulse_start(16'd8, 2'd1);
    check("a_trig", 32'(trig), 1);
    check("a_busy", 32'(busy), 1);
    check("a_phase", 32'(cap_phase), 1);
    repeat (4) step();
    rdy = 1'b1;
    wait_for("a_cmpt", 0, 40);
    check("a_trig_in_cmpt", 32'(trig), 0);
    step();
    check("a_hold_cmpt", 32'(cmpt), 1);
    d0 = done_n;
    rdy = 1'b0;
    wait_for("a_done", 1, 10);
    step();
    check("a_done_pulses", 32'(done_n - d0), 1);
    check("a_busy_end", 32'(busy), 0);
    check("a_cmpt_end", 32'(cmpt), 0);
    check("a_writes", 32'(addr_log.size()), 8);
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      check($sformatf("a_addr%0d", i), 32'(addr_log[i]), 32'(i));
      check($sformatf("a_data%0d", i), 32'(data_log[i]), 32'(exp_log[i]));
    end

    // len=4, overflow on exactly the first two captured samples
    clear_logs();
    pulse_start(16'd4, 2'd1);
    step();
    rdy = 1'b1;
    step();
    adc_of = 1'b1;
    step(); step();
    adc_of = 1'b0;
    wait_for("b_cmpt", 0, 20);
    rdy = 1'b0;
    wait_for("b_done", 1, 10);
    step();
    check("b_of_cnt", 32'(of_cnt), 2);
    of_writes = 0;
    foreach (data_log[i]) if (data_log[i][14]) of_writes++;
    check("b_of_writes", 32'(of_writes), 2);
    check("b_writes", 32'(addr_log.size()), 4);

    // rdy never rises -> timeout after 1024 REQ cycles
    clear_logs();
    d0 = err_n;
    pulse_start(16'd5, 2'd0);
    n = 0;
    while (!err && n < 1100) begin
      step();
      n++;
    end
    check("c_tmo_cycles", 32'(n), 1024);
    check("c_trig", 32'(trig), 0);
    check("c_cmpt", 32'(cmpt), 0);
    step();
    check("c_err_pulses", 32'(err_n - d0), 1);
    check("c_idle", 32'(busy), 0);
    check("c_writes", 32'(addr_log.size()), 0);

    // Abort at addr 3 of len=10
    clear_logs();
    d0 = done_n;
    pulse_start(16'd10, 2'd1);
    rdy = 1'b1;
    n = 0;
    while (!(wr_en && wr_addr == 16'd3) && n < 30) begin
      step();
      n++;
    end
    check("d_addr3_seen", 32'(wr_en && wr_addr == 16'd3), 1);
    abort = 1'b1;
    #1;
    check("d_wr_en_masked", 32'(wr_en), 0);
    check("d_trig_same", 32'(trig), 1);
    step();
    abort = 1'b0;
    check("d_trig_next", 32'(trig), 0);
    check("d_cmpt_next", 32'(cmpt), 0);
    step();
    check("d_rel_busy", 32'(busy), 1);
    rdy = 1'b0;
    step();
    check("d_idle", 32'(busy), 0);
    check("d_no_done", 32'(done_n - d0), 0);
    check("d_writes", 32'(addr_log.size()), 3);

    // len=0: REQ -> CMPT; start while busy and start with rdy high ignored
    clear_logs();
    pulse_start(16'd0, 2'd1);
    step();
    rdy = 1'b1;
    step();
    check("e_cmpt", 32'(cmpt), 1);
    check("e_trig", 32'(trig), 0);
    pulse_start(16'd7, 2'd3);
    check("e_busy_start_phase", 32'(cap_phase), 1);
    rdy = 1'b0;
    wait_for("e_done", 1, 10);
    step();
    check("e_writes", 32'(addr_log.size()), 0);
    rdy = 1'b1;
    pulse_start(16'd7, 2'd3);
    check("e_rdy_start_busy", 32'(busy), 0);
    check("e_rdy_start_phase", 32'(cap_phase), 1);
    rdy = 1'b0;
    step();

    // Reset mid-CAPT, then a fresh start with phase 2'b10
    d0 = done_n;
    pulse_start(16'd10, 2'd1);
    rdy = 1'b1;
    wait_for("f_capt", 2, 20);
    rst = 1'b1;
    step();
    check("f_trig", 32'(trig), 0);
    check("f_cmpt", 32'(cmpt), 0);
    check("f_wr_en", 32'(wr_en), 0);
    check("f_busy", 32'(busy), 0);
    check("f_phase", 32'(cap_phase), 0);
    check("f_of_cnt", 32'(of_cnt), 0);
    rst = 1'b0;
    rdy = 1'b0;
    step();
    check("f_no_done", 32'(done_n - d0), 0);
    clear_logs();
    pulse_start(16'd2, 2'b10);
    check("f2_phase", 32'(cap_phase), 2);
    check("f2_trig", 32'(trig), 1);
    rdy = 1'b1;
    wait_for("f2_cmpt", 0, 20);
    rdy = 1'b0;
    wait_for("f2_done", 1, 10);
    step();
    check("f2_writes", 32'(addr_log.size()), 2);
    check("f2_phase_hold", 32'(cap_phase), 2);

    // CAP0_0=8: longest run (len 255) with overflow held -> count pegs at 255
    adc_of = 1'b1;
    len8 = 8'd255; start8 = 1'b1;
    step();
    start8 = 1'b0;
    rdy8 = 1'b1;
    wait_for("g_cmpt8", 3, 400);
    rdy8 = 1'b0;
    adc_of = 1'b0;
    step(); step(); step();
    check("g_of_cnt8", 32'(of_cnt8), 255);
    check("g_writes8", 32'(wr8_n), 255);
    check("g_last_addr8", 32'(last_addr8), 254);
    check("g_idle8", 32'(busy8), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
